// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Provides the queue entry layout, instruction width and the NOP filler.
package fetch_pkg;

    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch addresses are word aligned; drop the byte offset.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Handshake bundles for the fetch stage.
// fetch_imem_if: req/addr out, gnt/rvalid/rdata in (master = fetch side).
// fetch_id_if:   valid/pc/inst out, ready in (master = fetch side).
interface fetch_imem_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr,
                    input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr,
                    output gnt, output rvalid, output rdata);
endinterface

interface fetch_id_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (output valid, output pc, output inst,
                    input ready);
    modport slave  (input valid, input pc, input inst,
                    output ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear.
// Ports: clk, rst, clr, push/wdata, pop/rdata (head), empty, full, count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push & ~do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (~do_push & do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// RV32I instruction fetch: sequential PC, imem reads, in-order queue to ID.
// Ports: clk, rst, imem (req/addr/gnt/rvalid/rdata), id (valid/pc/inst/ready),
//        redirect_valid/redirect_pc from EX.
module inst_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    fetch_imem_if.master        imem,
    fetch_id_if.master          id,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc
);

    localparam int          OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int          QCW    = $clog2(QUEUE_DEPTH + 1);
    localparam int          TCW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int          EW     = $bits(fetch_entry_t);
    localparam logic [31:0] MAX_OW = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] QD_W   = 32'(QUEUE_DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;

    logic         req;
    logic         gnt_fire;
    logic         rsp;
    logic         keep;
    logic [31:0]  credit;

    logic         q_push, q_pop, q_empty, q_full;
    logic [QCW-1:0] q_count;
    logic [EW-1:0]  q_wdata, q_rdata;
    fetch_entry_t q_head;

    logic         tag_empty, tag_full;
    logic [TCW-1:0] tag_count;
    logic [31:0]  tag_pc;

    // Every granted read must own a queue slot when its data returns.
    assign credit = 32'(q_count) + 32'(out_q);

    assign req = ~rst & ~redirect_valid
               & (32'(out_q) < MAX_OW)
               & (credit < QD_W);

    assign gnt_fire = req & imem.gnt;
    assign rsp      = imem.rvalid & (out_q != '0);
    assign keep     = rsp & (drop_q == '0);

    assign q_wdata = {tag_pc, imem.rdata};
    assign q_push  = keep & ~redirect_valid;
    assign q_head  = fetch_entry_t'(q_rdata);

    assign id.valid = ~q_empty & ~rst & ~redirect_valid;
    assign id.pc    = q_head.pc;
    assign id.inst  = q_empty ? NOP_INST : q_head.inst;
    assign q_pop    = id.valid & id.ready;

    assign imem.req  = req;
    assign imem.addr = pc_q;

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (gnt_fire) begin
            pc_d = pc_q + 32'(INST_BYTES);
        end
        if (gnt_fire & ~rsp) begin
            out_d = out_q + OW'(1);
        end else if (~gnt_fire & rsp) begin
            out_d = out_q - OW'(1);
        end
        if (rsp & (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end
        // Everything still in flight after this edge belongs to the old path.
        if (redirect_valid) begin
            pc_d   = align_pc(redirect_pc);
            drop_d = out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // PC of each live request, in grant order; dropped reads have no tag.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (gnt_fire),
        .wdata (pc_q),
        .pop   (keep),
        .rdata (tag_pc),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rvalid: assert (!(imem.rvalid && out_q == '0))
                else $error("rvalid with no outstanding read");
            a_tag_pop: assert (!(keep && tag_empty))
                else $error("response without pc tag");
            a_tag_push: assert (!(gnt_fire && tag_full && !keep))
                else $error("pc tag overflow");
            a_q_push: assert (!(q_push && q_full && !q_pop))
                else $error("fetch queue overflow");
            a_books: assert (32'(tag_count) + 32'(drop_q) == 32'(out_q))
                else $error("outstanding bookkeeping mismatch");
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with in-order imem model
// and scoreboard of expected {pc, inst} pairs toward ID.
module tb_inst_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_imem_if imem_bus ();
    fetch_id_if   id_bus ();

    inst_fetch_stage #(
        .RESET_PC        (32'h0000_0000),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .id             (id_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rd_t;

    rd_t          pend[$];
    fetch_entry_t sb[$];
    int           fire_cyc[$];
    fetch_entry_t mon_e;
    int           cyc = 0;
    int           lat = 1;
    int           grants = 0;
    int           n_pass = 0;
    int           n_total = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic expect_pc(input logic [31:0] p);
        sb.push_back('{pc: p, inst: mem_word(p)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: handshakes are sampled mid-cycle when all is settled.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            grants = 0;
        end else begin
            if (imem_bus.rvalid && pend.size() != 0) void'(pend.pop_front());
            if (imem_bus.req && imem_bus.gnt) begin
                pend.push_back('{due: cyc + lat, addr: imem_bus.addr});
                grants++;
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = mem_word(pend[0].addr);
        end else begin
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = 32'h0;
        end
    end

    // Monitor: every accepted ID transfer consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && id_bus.valid && id_bus.ready) begin
            fire_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got pc %h want none", id_bus.pc);
            end else begin
                mon_e = sb.pop_front();
                check("id_pc", id_bus.pc, mon_e.pc);
                check("id_inst", id_bus.inst, mon_e.inst);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_req", 32'(imem_bus.req), 32'd0);
        check("rst_valid", 32'(id_bus.valid), 32'd0);
        rst = 1'b0;
        fire_cyc.delete();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
        id_bus.ready = 1'b0;
    endtask

    task automatic gaps(input string nm, input int n);
        check({nm, "_fires"}, 32'(fire_cyc.size()), 32'(n));
        for (int i = 1; i < fire_cyc.size(); i++)
            check({nm, "_gap"}, 32'(fire_cyc[i] - fire_cyc[i-1]), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_bus.gnt   = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata = 32'h0;
        id_bus.ready   = 1'b0;

        // 1: streaming from reset at one-cycle latency
        lat = 1;
        imem_bus.gnt = 1'b1;
        do_reset();
        id_bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        drain("t1");
        gaps("t1", 4);

        // 2: decoder stall fills the queue, then release
        do_reset();
        repeat (10) tick();
        check("t2_req", 32'(imem_bus.req), 32'd0);
        check("t2_valid", 32'(id_bus.valid), 32'd1);
        check("t2_head_pc", id_bus.pc, 32'h0);
        check("t2_grants", 32'(grants), 32'd4);
        fire_cyc.delete();
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        id_bus.ready = 1'b1;
        drain("t2");
        gaps("t2", 8);

        // 3: redirect with two reads in flight
        lat = 3;
        do_reset();
        id_bus.ready = 1'b1;
        tick();
        tick();
        check("t3_inflight", 32'(pend.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_redir_req", 32'(imem_bus.req), 32'd0);
        check("t3_redir_valid", 32'(id_bus.valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        expect_pc(32'h100);
        expect_pc(32'h104);
        expect_pc(32'h108);
        drain("t3");

        // 4: misaligned redirect target
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_req", 32'(imem_bus.req), 32'd1);
        check("t4_addr", imem_bus.addr, 32'h200);
        expect_pc(32'h200);
        expect_pc(32'h204);
        expect_pc(32'h208);
        id_bus.ready = 1'b1;
        drain("t4");

        // 5: grant withheld, request must hold
        lat = 1;
        imem_bus.gnt = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_req", 32'(imem_bus.req), 32'd1);
            check("t5_addr", imem_bus.addr, 32'h0);
            tick();
        end
        imem_bus.gnt = 1'b1;
        id_bus.ready = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        drain("t5");

        // 6: reset in the middle of traffic
        lat = 3;
        do_reset();
        id_bus.ready = 1'b1;
        tick();
        tick();
        check("t6_inflight", 32'(pend.size()), 32'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(imem_bus.req), 32'd0);
        check("t6_rst_valid", 32'(id_bus.valid), 32'd0);
        do_reset();
        #1;
        check("t6_restart_addr", imem_bus.addr, 32'h0);
        check("t6_restart_req", 32'(imem_bus.req), 32'd1);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        id_bus.ready = 1'b1;
        drain("t6");

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
